serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_if.sv | 21 ++
 rtl/serial_add_ctrl.sv | 90 +++++++++
 tb/tb_serial_add_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand request and result handshake bundle for the byte-serial adder
interface serial_add_ctrl_if #(parameter int NBYTES = 16);
    localparam int W = 8 * NBYTES;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] sum_o;
    logic         cout_o;
    modport slave (
        input  in_valid_i, a_i, b_i, cin_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o, cout_o
    );
    modport master (
        output in_valid_i, a_i, b_i, cin_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o, cout_o
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: wide add done one byte per cycle through a single 8-bit adder slice
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [8:0] s
);
    assign s = {1'b0, a} + {1'b0, b};
endmodule

module serial_add_ctrl #(
    parameter int NBYTES = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    serial_add_ctrl_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  res_q;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          cout_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [8:0]    s1;
    logic [8:0]    s2;
    logic          carry_next;

    // The slice adds the low operand bytes, then folds in the carry kept from the previous slice.
    adder_8bit u_s1 (.a(a_q[7:0]), .b(b_q[7:0]), .s(s1));
    adder_8bit u_s2 (.a(s1[7:0]), .b({7'b0, carry}), .s(s2));

    assign carry_next      = s1[8] | s2[8];
    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.sum_o       = res_q;
    assign bus.cout_o      = cout_q;

    // Accept operands, ripple one byte per cycle, then hold the result until it is taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt         <= '0;
            carry       <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid_i) begin
                    a_q        <= bus.a_i;
                    b_q        <= bus.b_i;
                    carry      <= bus.cin_i;
                    cnt        <= '0;
                    in_ready_q <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    a_q   <= a_q >> 8;
                    b_q   <= b_q >> 8;
                    res_q <= {s2[7:0], res_q[W-1:8]};
                    carry <= carry_next;
                    if (cnt == CW'(NBYTES - 1)) begin
                        cnt         <= '0;
                        cout_q      <= carry_next;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: if (bus.out_ready_i) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of the byte-serial adder against exact arithmetic
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int errs = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.NBYTES(4))  b4 ();
    serial_add_ctrl_if #(.NBYTES(16)) b16 ();

    serial_add_ctrl #(.NBYTES(4))  dut4  (.clk_i(clk), .rst_ni(rst_n), .bus(b4.slave));
    serial_add_ctrl #(.NBYTES(16)) dut16 (.clk_i(clk), .rst_ni(rst_n), .bus(b16.slave));

    task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start4(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic ordy);
        b4.a_i         = a;
        b4.b_i         = b;
        b4.cin_i       = cin;
        b4.out_ready_i = ordy;
        b4.in_valid_i  = 1'b1;
        @(negedge clk);
        b4.in_valid_i  = 1'b0;
    endtask

    task automatic wait4(input string tag);
        int lat;
        lat = 0;
        while (!b4.out_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 129'(lat), 129'(4));
    endtask

    task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic cin, input string tag);
        logic [32:0] exp;
        exp = {1'b0, a} + {1'b0, b} + 33'(cin);
        check({tag, "_in_ready"}, 129'(b4.in_ready_o), 129'(1));
        start4(a, b, cin, 1'b1);
        wait4(tag);
        check({tag, "_sum"}, 129'({b4.cout_o, b4.sum_o}), 129'(exp));
        @(negedge clk);
        check({tag, "_ready_back"}, 129'({b4.in_ready_o, b4.out_valid_o}), 129'(2'b10));
    endtask

    initial begin
        logic [32:0]  exp4;
        logic [127:0] a16;
        logic [127:0] b16v;
        logic         c16;
        logic [128:0] exp16;
        int           lat;
        int           stall;
        b4.in_valid_i   = 1'b0;
        b4.a_i          = '0;
        b4.b_i          = '0;
        b4.cin_i        = 1'b0;
        b4.out_ready_i  = 1'b0;
        b16.in_valid_i  = 1'b0;
        b16.a_i         = '0;
        b16.b_i         = '0;
        b16.cin_i       = 1'b0;
        b16.out_ready_i = 1'b0;
        @(negedge clk);
        check("reset4", 129'({b4.in_ready_o, b4.out_valid_o, b4.cout_o, b4.sum_o}), 129'({2'b10, 33'b0}));
        check("reset16", 129'({b16.in_ready_o, b16.out_valid_o, b16.cout_o}), 129'(3'b100));
        check("reset16_sum", 129'(b16.sum_o), 129'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run4(32'h0000_0001, 32'h0000_0002, 1'b0, "small");
        run4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "ripple_b");
        run4(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "ripple_cin");
        run4(32'h00FF_FFFF, 32'h0000_0000, 1'b1, "partial");
        run4(32'h8000_0000, 32'h8000_0000, 1'b0, "top_carry");

        exp4 = {1'b0, 32'hDEAD_BEEF} + {1'b0, 32'h2152_4111} + 33'd1;
        start4(32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 1'b0);
        wait4("bp");
        check("bp_sum", 129'({b4.cout_o, b4.sum_o}), 129'(exp4));
        for (int i = 0; i < 6; i++) begin
            b4.in_valid_i = 1'b1;
            b4.a_i        = $urandom;
            b4.b_i        = $urandom;
            b4.cin_i      = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_hold_sum", 129'({b4.cout_o, b4.sum_o}), 129'(exp4));
            check("bp_hold_hs", 129'({b4.in_ready_o, b4.out_valid_o}), 129'(2'b01));
        end
        b4.in_valid_i  = 1'b0;
        b4.out_ready_i = 1'b1;
        @(negedge clk);
        check("bp_release", 129'({b4.in_ready_o, b4.out_valid_o}), 129'(2'b10));
        run4(32'h0000_FFFF, 32'h0000_0001, 1'b0, "after_bp");

        start4(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("midrst", 129'({b4.in_ready_o, b4.out_valid_o, b4.cout_o, b4.sum_o}), 129'({2'b10, 33'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run4(32'h1234_5678, 32'h1111_1111, 1'b0, "post_rst");

        for (int n = 0; n < 1000; n++) begin
            a16  = {$urandom, $urandom, $urandom, $urandom};
            b16v = {$urandom, $urandom, $urandom, $urandom};
            c16  = 1'($urandom_range(0, 1));
            if (n % 50 == 0) begin
                a16  = '1;
                b16v = '0;
                c16  = 1'b1;
            end
            exp16 = {1'b0, a16} + {1'b0, b16v} + 129'(c16);
            lat = 0;
            while (!b16.in_ready_o && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            b16.a_i         = a16;
            b16.b_i         = b16v;
            b16.cin_i       = c16;
            b16.out_ready_i = 1'b0;
            b16.in_valid_i  = 1'b1;
            @(negedge clk);
            b16.in_valid_i  = 1'b0;
            lat = 0;
            while (!b16.out_valid_o && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            check("rand_latency", 129'(lat), 129'(16));
            check("rand_sum", {b16.cout_o, b16.sum_o}, exp16);
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("rand_hold", {b16.cout_o, b16.sum_o, b16.out_valid_o} >> 1, exp16);
            end
            b16.out_ready_i = 1'b1;
            @(negedge clk);
            b16.out_ready_i = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
